// File: rtl/mf_clken_pkg.sv
// mf_clken_pkg: shared defaults, FSM state type, channel config struct and write validation for mf_clken_gen
package mf_clken_pkg;
  localparam int DEF_ACC_W = 16;
  localparam int CFG_W = 32;
  typedef enum logic [1:0] {RESTART = 2'd0, SETTLE = 2'd1, LOCKED = 2'd2} state_t;
  typedef struct packed {
    logic [CFG_W-1:0] num;
    logic [CFG_W-1:0] den;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;
  function automatic logic cfg_reject(chan_cfg_t c, logic [CFG_W-1:0] ch, logic [CFG_W-1:0] nch);
    return c.den == '0 || c.num > c.den || c.phase >= c.den || ch >= nch;
  endfunction
endpackage

// File: rtl/mf_clken_if.sv
// mf_clken_if: config port (cfg_valid/cfg_ready/cfg_ch/cfg_num/cfg_den/cfg_phase/cfg_err/cfg_commit), master drives requests, slave answers
interface mf_clken_if import mf_clken_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ACC_W = DEF_ACC_W
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic cfg_valid, cfg_ready, cfg_err, cfg_commit;
  logic [CH_W-1:0] cfg_ch;
  logic [ACC_W-1:0] cfg_num, cfg_den, cfg_phase;
  modport master(output cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_phase, cfg_commit, input cfg_ready, cfg_err);
  modport slave(input cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_phase, cfg_commit, output cfg_ready, cfg_err);
endinterface

// File: rtl/mf_clken_acc.sv
// mf_clken_acc: one fractional accumulator channel; ports clk, rst, restart, num/den/phase in, ce (and div_clk with MF_CLKEN_DIV_OUT_EN) out
module mf_clken_acc import mf_clken_pkg::*; #(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  input  logic [ACC_W-1:0] phase,
  output logic             ce
`ifdef MF_CLKEN_DIV_OUT_EN
  ,
  output logic             div_clk
`endif
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic hit;
  assign sum = {1'b0, acc} + {1'b0, num};
  assign hit = sum >= {1'b0, den};
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      acc <= rst ? '0 : phase;
      ce <= 1'b0;
    end else begin
      acc <= hit ? ACC_W'(sum - {1'b0, den}) : ACC_W'(sum);
      ce <= hit;
    end
  end
`ifdef MF_CLKEN_DIV_OUT_EN
  always_ff @(posedge clk) div_clk <= (rst || restart) ? 1'b0 : div_clk ^ hit;
`endif
endmodule

// File: rtl/mf_clken_gen.sv
// mf_clken_gen: multi-channel fractional clock-enable generator; ports refclk, rst, cfg (mf_clken_if.slave), ce, locked, div_clk when MF_CLKEN_DIV_OUT_EN is defined
module mf_clken_gen import mf_clken_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ACC_W = DEF_ACC_W,
  parameter int DEF_NUM = 1,
  parameter int DEF_DEN = 2,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              refclk,
  input  logic              rst,
  mf_clken_if.slave         cfg,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
`ifdef MF_CLKEN_DIV_OUT_EN
  ,
  output logic [NUM_CH-1:0] div_clk
`endif
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sh_num [NUM_CH];
  logic [ACC_W-1:0] sh_den [NUM_CH];
  logic [ACC_W-1:0] sh_ph [NUM_CH];
  logic [ACC_W-1:0] ac_num [NUM_CH];
  logic [ACC_W-1:0] ac_den [NUM_CH];
  chan_cfg_t req;
  logic rej, wr, restart;
  assign restart = state == RESTART;
  assign cfg.cfg_ready = !restart;
  assign req = '{num: CFG_W'(cfg.cfg_num), den: CFG_W'(cfg.cfg_den), phase: CFG_W'(cfg.cfg_phase)};
  assign rej = cfg_reject(req, CFG_W'(cfg.cfg_ch), CFG_W'(NUM_CH));
  assign wr = cfg.cfg_valid && cfg.cfg_ready && !rej;
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= RESTART;
      cnt <= '0;
      locked <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      locked <= state == LOCKED;
      cfg.cfg_err <= cfg.cfg_valid && cfg.cfg_ready && rej;
      cnt <= restart ? '0 : cnt + 1'b1;
      state <= restart ? SETTLE :
               cfg.cfg_commit ? RESTART :
               (state == SETTLE && cnt == CNT_W'(LOCK_CYCLES - 1)) ? LOCKED : state;
    end
  end
  // A write and a commit in the same cycle land in shadow first; the following RESTART copies it.
  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        sh_num[i] <= ACC_W'(DEF_NUM);
        sh_den[i] <= ACC_W'(DEF_DEN);
        sh_ph[i] <= '0;
        ac_num[i] <= ACC_W'(DEF_NUM);
        ac_den[i] <= ACC_W'(DEF_DEN);
      end else begin
        if (wr && cfg.cfg_ch == CH_W'(i)) begin
          sh_num[i] <= cfg.cfg_num;
          sh_den[i] <= cfg.cfg_den;
          sh_ph[i] <= cfg.cfg_phase;
        end
        if (restart) begin
          ac_num[i] <= sh_num[i];
          ac_den[i] <= sh_den[i];
        end
      end
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mf_clken_acc #(.ACC_W(ACC_W)) u_acc (
      .clk(refclk),
      .rst(rst),
      .restart(restart),
      .num(ac_num[c]),
      .den(ac_den[c]),
      .phase(sh_ph[c]),
      .ce(ce[c])
`ifdef MF_CLKEN_DIV_OUT_EN
      ,
      .div_clk(div_clk[c])
`endif
    );
  end
endmodule

// File: tb/tb_mf_clken_gen.sv
// tb_mf_clken_gen: scoreboard bench for mf_clken_gen with per-scenario tasks
module tb_mf_clken_gen;
  localparam int NUM_CH = 3;
  localparam int LOCK = 64;
`ifdef MF_CLKEN_DIV_OUT_EN
  localparam int VW = 2 * NUM_CH + 3;
`else
  localparam int VW = NUM_CH + 3;
`endif
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] ce;
  logic locked;
`ifdef MF_CLKEN_DIV_OUT_EN
  logic [NUM_CH-1:0] div_clk;
`endif
  mf_clken_if #(.NUM_CH(NUM_CH), .ACC_W(16)) cfg();
  mf_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(16), .DEF_NUM(1), .DEF_DEN(2), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg(cfg),
    .ce(ce),
    .locked(locked)
`ifdef MF_CLKEN_DIV_OUT_EN
    ,
    .div_clk(div_clk)
`endif
  );
  always #5 refclk = ~refclk;
  int n_vec = 0;
  int n_bad = 0;
  logic [VW-1:0] exp_q[$];
  longint m_sn[NUM_CH], m_sd[NUM_CH], m_sp[NUM_CH], m_an[NUM_CH], m_ad[NUM_CH], m_ap[NUM_CH];
  logic [NUM_CH-1:0] m_div;
  int rk;
  // Enable after running step k: the integer part of (phase + k*num)/den advanced.
  function automatic logic fire(longint p, longint n, longint d, longint k);
    return (p + k * n) / d != (p + (k - 1) * n) / d;
  endfunction
  function automatic logic rej_m(longint ch, longint n, longint d, longint p);
    return d == 0 || n > d || p >= d || ch >= NUM_CH;
  endfunction
  // Model one refclk edge from the current inputs, queue the expected outputs, advance the clock.
  task automatic cyc();
    logic [NUM_CH-1:0] e_ce;
    logic e_lk, e_err, e_rdy, rdy;
    e_ce = '0;
    e_lk = 1'b0;
    e_err = 1'b0;
    rdy = rk >= 0;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sn[i] = 1; m_sd[i] = 2; m_sp[i] = 0;
        m_an[i] = 1; m_ad[i] = 2; m_ap[i] = 0;
      end
      m_div = '0;
      rk = -1;
    end else begin
      int ch;
      ch = int'(cfg.cfg_ch);
      e_err = cfg.cfg_valid && rdy && rej_m(ch, cfg.cfg_num, cfg.cfg_den, cfg.cfg_phase);
      if (cfg.cfg_valid && rdy && !e_err) begin
        m_sn[ch] = cfg.cfg_num; m_sd[ch] = cfg.cfg_den; m_sp[ch] = cfg.cfg_phase;
      end
      e_lk = rk >= LOCK;
      if (rk < 0) begin
        m_an = m_sn; m_ad = m_sd; m_ap = m_sp;
        m_div = '0;
        rk = 0;
      end else begin
        rk++;
        for (int i = 0; i < NUM_CH; i++) begin
          e_ce[i] = fire(m_ap[i], m_an[i], m_ad[i], rk);
          m_div[i] = m_div[i] ^ e_ce[i];
        end
        if (cfg.cfg_commit) rk = -1;
      end
    end
    e_rdy = rk >= 0;
`ifdef MF_CLKEN_DIV_OUT_EN
    exp_q.push_back({e_ce, e_lk, e_err, e_rdy, m_div});
`else
    exp_q.push_back({e_ce, e_lk, e_err, e_rdy});
`endif
    @(posedge refclk);
    #1;
  endtask
  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e, got;
      e = exp_q.pop_front();
`ifdef MF_CLKEN_DIV_OUT_EN
      got = {ce, locked, cfg.cfg_err, cfg.cfg_ready, div_clk};
`else
      got = {ce, locked, cfg.cfg_err, cfg.cfg_ready};
`endif
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t {ce,locked,err,ready[,div]} got=%b exp=%b", $time, got, e);
      end
    end
  end
  task automatic wr(input int ch, input int n, input int d, input int p, input logic commit);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = ch[1:0];
    cfg.cfg_num = n[15:0];
    cfg.cfg_den = d[15:0];
    cfg.cfg_phase = p[15:0];
    cfg.cfg_commit = commit;
    cyc();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_commit = 1'b0;
  endtask
  task automatic commit();
    cfg.cfg_commit = 1'b1;
    cyc();
    cfg.cfg_commit = 1'b0;
  endtask
  task automatic test_reset();
    int first;
    rst = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if ({ce, locked, cfg.cfg_err, cfg.cfg_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=0", {ce, locked, cfg.cfg_err, cfg.cfg_ready});
    end
    rst = 1'b0;
    first = 0;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (n == 2 || n == 3) begin
        n_vec++;
        if (ce !== (n == 3 ? 3'b111 : 3'b000)) begin
          n_bad++;
          $display("FAIL reset_first_ce n=%0d got=%b exp=%b", n, ce, (n == 3 ? 3'b111 : 3'b000));
        end
      end
      if (locked === 1'b1 && first == 0) first = n;
    end
    n_vec++;
    if (first !== 66) begin
      n_bad++;
      $display("FAIL reset_lock_latency got=%0d exp=66", first);
    end
  endtask
  task automatic test_ratio();
    int p0, p1, first;
    wr(1, 3, 7, 0, 1'b0);
    commit();
    n_vec++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_hold_after_commit got=%b exp=1", locked); end
    cyc();
    n_vec++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_drop got=%b exp=0", locked); end
    p0 = 0; p1 = 0; first = 0;
    for (int j = 1; j <= 700; j++) begin
      cyc();
      p0 += int'(ce[0]);
      p1 += int'(ce[1]);
      if (locked === 1'b1 && first == 0) first = j;
    end
    n_vec++;
    if (p1 !== 300) begin n_bad++; $display("FAIL ratio_3_7 pulses got=%0d exp=300", p1); end
    n_vec++;
    if (p0 !== 350) begin n_bad++; $display("FAIL ratio_ch0 pulses got=%0d exp=350", p0); end
    n_vec++;
    if (first !== 65) begin n_bad++; $display("FAIL relock got=%0d exp=65", first); end
  endtask
  task automatic test_phase();
    wr(2, 1, 2, 1, 1'b0);
    commit();
    cyc();
    cyc();
    n_vec++;
    if ({ce[2], ce[0]} !== 2'b10) begin n_bad++; $display("FAIL phase_first got=%b exp=10", {ce[2], ce[0]}); end
    cyc();
    n_vec++;
    if ({ce[2], ce[0]} !== 2'b01) begin n_bad++; $display("FAIL phase_second got=%b exp=01", {ce[2], ce[0]}); end
  endtask
  task automatic test_illegal();
    int errs, p0, p1;
    errs = 0;
    wr(0, 1, 0, 0, 1'b0); errs += int'(cfg.cfg_err); cyc(); errs += int'(cfg.cfg_err);
    wr(0, 5, 4, 0, 1'b0); errs += int'(cfg.cfg_err); cyc(); errs += int'(cfg.cfg_err);
    wr(0, 1, 9, 9, 1'b0); errs += int'(cfg.cfg_err); cyc(); errs += int'(cfg.cfg_err);
    wr(3, 1, 2, 0, 1'b0); errs += int'(cfg.cfg_err); cyc(); errs += int'(cfg.cfg_err);
    n_vec++;
    if (errs !== 4) begin n_bad++; $display("FAIL illegal_err_pulses got=%0d exp=4", errs); end
    commit();
    cyc();
    p0 = 0; p1 = 0;
    for (int j = 0; j < 14; j++) begin
      cyc();
      p0 += int'(ce[0]);
      p1 += int'(ce[1]);
    end
    n_vec++;
    if ({p0, p1} !== {32'd7, 32'd6}) begin n_bad++; $display("FAIL illegal_ratios got=%0d/%0d exp=7/6", p0, p1); end
  endtask
  task automatic test_back_to_back();
    int p0, first;
    wr(0, 1, 3, 0, 1'b1);
    cyc();
    p0 = 0;
    for (int j = 0; j < 30; j++) begin
      cyc();
      p0 += int'(ce[0]);
    end
    n_vec++;
    if (p0 !== 10) begin n_bad++; $display("FAIL wr_commit_ratio got=%0d exp=10", p0); end
    commit();
    first = 0;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (locked === 1'b1 && first == 0) first = n;
    end
    n_vec++;
    if (first !== 66) begin n_bad++; $display("FAIL settle_commit_lock got=%0d exp=66", first); end
  endtask
  task automatic test_reset_mid();
    int p1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if ({ce, locked} !== '0) begin n_bad++; $display("FAIL mid_reset got=%b exp=0", {ce, locked}); end
`ifdef MF_CLKEN_DIV_OUT_EN
    n_vec++;
    if (div_clk !== '0) begin n_bad++; $display("FAIL mid_reset_div got=%b exp=0", div_clk); end
`endif
    cyc();
    p1 = 0;
    for (int j = 0; j < 40; j++) begin
      cyc();
      p1 += int'(ce[1]);
    end
    n_vec++;
    if (p1 !== 20) begin n_bad++; $display("FAIL mid_reset_ch1 got=%0d exp=20", p1); end
  endtask
  initial begin
    rk = -1;
    m_div = '0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_commit = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_num = '0;
    cfg.cfg_den = '0;
    cfg.cfg_phase = '0;
    test_reset();
    test_ratio();
    test_phase();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    @(negedge refclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mf_clken_gen.md
Name: mf_clken_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator, clocked from a single PLL output (e.g. 85.909090 MHz).
- Replaces fixed extra PLL taps: each channel emits a one-cycle enable at average rate refclk*NUM/DEN, with a programmable phase offset.
- Ratios are runtime reprogrammable through a valid/ready config port. A commit strobe restarts all channels phase-aligned.
- `locked` mirrors PLL lock semantics for downstream reset sequencing.

Parameters:
- NUM_CH, 3, number of enable channels (1..16).
- ACC_W, 16, width of numerator/denominator/phase/accumulator.
- DEF_NUM, 1, reset numerator for every channel.
- DEF_DEN, 2, reset denominator for every channel.
- LOCK_CYCLES, 64, cycles after restart before `locked` asserts (>=1).

Ports:
- refclk  in  1  block clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
- cfg_num  in  ACC_W  numerator.
- cfg_den  in  ACC_W  denominator.
- cfg_phase  in  ACC_W  initial accumulator value.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- cfg_commit  in  1  pulse: copy shadow to active, restart all channels.
- ce  out  NUM_CH  per-channel clock enable, registered.
- locked  out  1  high once LOCK_CYCLES elapsed since last restart.

Behaviour:
- Reset (rst=1 at a refclk edge):
  - shadow and active = {DEF_NUM, DEF_DEN, phase 0} for all channels.
  - ce=0, locked=0, cfg_ready=0, cfg_err=0.
  - FSM enters RESTART.
- FSM RESTART (one cycle):
  - active <= shadow; acc[i] <= phase[i]; ce <= 0.
  - lock counter <= 0; cfg_ready=0.
  - Next state: SETTLE.
- FSM SETTLE:
  - Channels run and cfg_ready=1.
  - The counter increments each cycle. When it reaches LOCK_CYCLES-1, go to LOCKED; locked=1 from the next cycle.
- FSM LOCKED: channels run, cfg_ready=1, locked=1.
- cfg_commit in SETTLE or LOCKED goes to RESTART; locked drops the next cycle. cfg_commit during RESTART is ignored.
- Channel step, per cycle when not in RESTART:
  - sum = acc + num, computed at ACC_W+1 bits (no overflow).
  - If sum >= den: acc <= sum-den, ce[i] <= 1. Otherwise acc <= sum, ce[i] <= 0.
- Boundary cases:
  - num=0: ce never fires.
  - num=den: ce is high every running cycle.
  - phase = den-num: ce fires on the first running cycle after RESTART.
- Config write:
  - Accepted on cfg_valid & cfg_ready. Updates shadow only; active is untouched until commit.
  - Rejected (shadow unchanged, cfg_err pulses the next cycle) if any of: den=0, num>den, phase>=den, cfg_ch>=NUM_CH.
- Write and commit in the same cycle: the write lands in shadow first, and that RESTART uses it.
- Reset mid-operation: all state returns to defaults in that cycle and the sequence restarts; no partial config survives.
- Latency: after reset deasserts, first ce at the earliest 2 cycles later; locked at reset release + 1 + LOCK_CYCLES + 1.

Optional Feature:
- Macro: MF_CLKEN_DIV_OUT_EN.
- When defined: adds output div_clk [NUM_CH], where each bit toggles on cycles its ce is registered high. div_clk is 0 at reset and forced to 0 in RESTART, giving a square wave at half the enable rate.
- When undefined: the port and its registers do not exist; all other behaviour is identical.

Decomposition:
- Package mf_clken_pkg: ACC_W default, state enum {RESTART, SETTLE, LOCKED}, channel config struct {num, den, phase}, and a validation function returning the reject flag.
- Sub-module mf_clken_acc: one fractional accumulator channel, holding acc, ce and the optional div_clk. Instantiated NUM_CH times in a generate loop.
- Top level holds the FSM, lock counter, shadow/active banks and the config port.

Test Plan:
1. Reset defaults (1/2), release rst → ce[0..2] each pulse every 2nd cycle, phase-aligned; locked=1 exactly 66 cycles after release.
2. Write ch1 num=3 den=7 phase=0, commit → ch1 gives exactly 3 pulses per 7 cycles over 700 cycles (300 total); ch0/ch2 unchanged; locked drops 1 cycle after commit and returns after 65 more.
3. Write ch2 phase = den-num = 1 (1/2), commit → ch2 pulses on the first running cycle while ch0 pulses on the second.
4. Illegal writes (den=0; num=5 den=4; phase=9 den=9; cfg_ch=3) → cfg_err pulses once each; a later commit shows unchanged ratios.
5. Write and commit in the same cycle (ch0 num=1 den=3) → that RESTART uses 1/3; also assert commit during SETTLE at count 30 → locked is delayed by a full LOCK_CYCLES.
6. Assert rst for 1 cycle mid-LOCKED with ch1 at 3/7 → all channels return to 1/2, ce=0, locked=0; with MF_CLKEN_DIV_OUT_EN, div_clk=0 and then toggles at refclk/4.
